axil_slave_bridge: RTL and testbench

Parametrised AXI4-Lite slave that converts the five AXI4-Lite channels into a simple register-bus strobe interface: wr_en/wr_addr/wr_data/wr_strobe for writes and rd_en/rd_addr/rd_data for reads. It is the successor to the fixed 32-bit slave and adds the following:
- AW and W accepted in either order, or in the same cycle.
- Address-window decode with SLVERR/DECERR responses.
- Strobe forwarding.
- Configurable read-data latency on the backend.
All outputs are registered.

---
 rtl/axil_pkg.sv | 35 +++
 rtl/axil_addr_decode.sv | 43 ++++
 rtl/axil_slave_bridge.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_axil_slave_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axil_pkg
// Brief    : Shared types and helpers for the AXI4-Lite register-bus bridge.
// Revision : 1.0
// ============================================================================
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // Wide enough to count up to the largest read latency (4).
  localparam int RD_CNT_W = 3;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : axil_addr_decode
// Brief    : Window and alignment check producing an AXI response code.
// Revision : 1.0
// ============================================================================
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_SPAN = 4096
) (
  input  logic [ADDR_W-1:0] addr,
  output resp_t             resp
);

  localparam int              c_lsb_w = $clog2(strb_width(DATA_W));
  localparam logic [ADDR_W:0] c_lo    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] c_span  = (ADDR_W + 1)'(ADDR_SPAN);

  logic [ADDR_W:0] w_offset;
  logic            w_in_window;
  logic            w_misaligned;

  // An address below the base borrows into the extra top bit, so a single
  // unsigned compare of the offset covers both window edges.
  always_comb begin
    w_offset     = {1'b0, addr} - c_lo;
    w_in_window  = (w_offset < c_span);
    w_misaligned = |addr[c_lsb_w-1:0];
    if (!w_in_window) begin
      resp = DECERR;
    end else if (w_misaligned) begin
      resp = SLVERR;
    end else begin
      resp = OKAY;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axil_slave_bridge
// Brief    : AXI4-Lite slave to register-bus strobe bridge, registered outputs.
// Revision : 1.0
// ============================================================================
module axil_slave_bridge
  import axil_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                ADDR_SPAN  = 4096,
  parameter int                RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AWvalid,
  input  logic [ADDR_W-1:0]     AWaddr,
  output logic                  AWready,
  input  logic                  Wvalid,
  input  logic [DATA_W-1:0]     Wdata,
  input  logic [DATA_W/8-1:0]   Wstrb,
  output logic                  Wready,
  output logic                  Bvalid,
  input  logic                  Bready,
  output logic [1:0]            Bresp,
  input  logic                  ARvalid,
  input  logic [ADDR_W-1:0]     ARaddr,
  output logic                  ARready,
  output logic                  Rvalid,
  input  logic                  Rready,
  output logic [DATA_W-1:0]     Rdata,
  output logic [1:0]            Rresp,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_strobe,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data
);

  localparam int                  c_strb_w   = strb_width(DATA_W);
  localparam logic [RD_CNT_W-1:0] c_last_cnt = RD_CNT_W'(RD_LATENCY - 1);

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  wr_state_t            r_wstate,   w_wstate_nxt;
  logic                 r_aw_held,  w_aw_held_nxt;
  logic                 r_w_held,   w_w_held_nxt;
  logic [ADDR_W-1:0]    r_awaddr,   w_awaddr_nxt;
  logic [DATA_W-1:0]    r_wdata,    w_wdata_nxt;
  logic [c_strb_w-1:0]  r_wstrb,    w_wstrb_nxt;
  logic                 r_awready,  w_awready_nxt;
  logic                 r_wready,   w_wready_nxt;
  logic                 r_wr_en,    w_wr_en_nxt;
  logic                 r_bvalid,   w_bvalid_nxt;
  resp_t                r_bresp,    w_bresp_nxt;

  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic [ADDR_W-1:0]    w_awaddr_cur;
  logic [c_strb_w-1:0]  w_wstrb_cur;
  resp_t                w_aw_resp;

  assign w_aw_hs      = r_awready & AWvalid;
  assign w_w_hs       = r_wready & Wvalid;
  // Decode sees the address/strobe as they will be once captured, so the
  // write pulse can be registered on the same edge that completes the pair.
  assign w_awaddr_cur = w_aw_hs ? AWaddr : r_awaddr;
  assign w_wstrb_cur  = w_w_hs  ? Wstrb  : r_wstrb;

  axil_addr_decode #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_SPAN (ADDR_SPAN)
  ) u_aw_decode (
    .addr (w_awaddr_cur),
    .resp (w_aw_resp)
  );

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_awaddr_nxt  = r_awaddr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_wr_en_nxt   = 1'b0;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) begin
          w_awaddr_nxt  = AWaddr;
          w_aw_held_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wdata_nxt  = Wdata;
          w_wstrb_nxt  = Wstrb;
          w_w_held_nxt = 1'b1;
        end
        if (w_aw_held_nxt && w_w_held_nxt) begin
          w_wstate_nxt = W_EXEC;
          w_bresp_nxt  = w_aw_resp;
          w_wr_en_nxt  = (w_aw_resp == OKAY) && (|w_wstrb_cur);
        end else begin
          w_awready_nxt = !w_aw_held_nxt;
          w_wready_nxt  = !w_w_held_nxt;
        end
      end
      W_EXEC: begin
        w_wstate_nxt = W_RESP;
        w_bvalid_nxt = 1'b1;
      end
      W_RESP: begin
        if (Bready) begin
          w_wstate_nxt  = W_IDLE;
          w_bvalid_nxt  = 1'b0;
          w_bresp_nxt   = OKAY;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  assign AWready   = r_awready;
  assign Wready    = r_wready;
  assign Bvalid    = r_bvalid;
  assign Bresp     = r_bresp;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_awaddr;
  assign wr_data   = r_wdata;
  assign wr_strobe = r_wstrb;

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  rd_state_t             r_rstate,  w_rstate_nxt;
  logic [ADDR_W-1:0]     r_araddr,  w_araddr_nxt;
  logic [RD_CNT_W-1:0]   r_rd_cnt,  w_rd_cnt_nxt;
  logic                  r_arready, w_arready_nxt;
  logic                  r_rd_en,   w_rd_en_nxt;
  logic                  r_rvalid,  w_rvalid_nxt;
  logic [DATA_W-1:0]     r_rdata,   w_rdata_nxt;
  resp_t                 r_rresp,   w_rresp_nxt;

  logic                  w_ar_hs;
  resp_t                 w_ar_resp;

  assign w_ar_hs = r_arready & ARvalid;

  axil_addr_decode #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_SPAN (ADDR_SPAN)
  ) u_ar_decode (
    .addr (ARaddr),
    .resp (w_ar_resp)
  );

  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_araddr_nxt  = r_araddr;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_arready_nxt = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (w_ar_hs) begin
          w_araddr_nxt  = ARaddr;
          w_arready_nxt = 1'b0;
          if (w_ar_resp == OKAY) begin
            w_rstate_nxt = R_WAIT;
            w_rd_en_nxt  = 1'b1;
            w_rd_cnt_nxt = '0;
          end else begin
            // Errored reads never touch the backend.
            w_rstate_nxt = R_DATA;
            w_rvalid_nxt = 1'b1;
            w_rdata_nxt  = '0;
            w_rresp_nxt  = w_ar_resp;
          end
        end
      end
      R_WAIT: begin
        if (r_rd_cnt == c_last_cnt) begin
          w_rstate_nxt = R_DATA;
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = rd_data;
          w_rresp_nxt  = OKAY;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + 1'b1;
        end
      end
      R_DATA: begin
        if (Rready) begin
          w_rstate_nxt  = R_IDLE;
          w_rvalid_nxt  = 1'b0;
          w_rresp_nxt   = OKAY;
          w_arready_nxt = 1'b1;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_araddr  <= '0;
      r_rd_cnt  <= '0;
      r_arready <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_araddr  <= w_araddr_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_arready <= w_arready_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  assign ARready = r_arready;
  assign Rvalid  = r_rvalid;
  assign Rdata   = r_rdata;
  assign Rresp   = r_rresp;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_araddr;

endmodule
`default_nettype wire

// File: tb/tb_axil_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_slave_bridge
// Brief    : Self-checking bench for axil_slave_bridge (table + random).
// Revision : 1.0
// ============================================================================
module tb_axil_slave_bridge;

  localparam int          RD_LAT = 3;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          SPAN   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        AWvalid = 1'b0, Wvalid = 1'b0, Bready = 1'b0, ARvalid = 1'b0, Rready = 1'b0;
  logic [31:0] AWaddr = '0, Wdata = '0, ARaddr = '0;
  logic [3:0]  Wstrb = '0;
  logic        AWready, Wready, Bvalid, ARready, Rvalid, wr_en, rd_en;
  logic [1:0]  Bresp, Rresp;
  logic [31:0] Rdata, wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  wr_strobe;

  int cyc = 0;
  int vecs = 0;
  int mis = 0;
  int n_wr = 0, n_rd = 0;
  int exp_wr_n = 0, exp_rd_n = 0;
  logic rd_const = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Backend read data changes every cycle so the sampling cycle is observable.
  function automatic logic [31:0] rd_val(input int c);
    logic [31:0] cv;
    cv = c;
    return (cv * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always_comb rd_data = rd_const ? 32'hCAFE_F00D : rd_val(cyc);

  always @(negedge clk) begin
    if (wr_en) n_wr <= n_wr + 1;
    if (rd_en) n_rd <= n_rd + 1;
  end

  axil_slave_bridge #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .ADDR_SPAN(SPAN), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .AWvalid(AWvalid), .AWaddr(AWaddr), .AWready(AWready),
    .Wvalid(Wvalid), .Wdata(Wdata), .Wstrb(Wstrb), .Wready(Wready),
    .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
    .ARvalid(ARvalid), .ARaddr(ARaddr), .ARready(ARready),
    .Rvalid(Rvalid), .Rready(Rready), .Rdata(Rdata), .Rresp(Rresp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    vecs++;
    mis++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Reference decode straight from the window/alignment rules.
  function automatic logic [1:0] model_resp(input logic [31:0] a);
    longint unsigned ua, lo, hi;
    ua = a;
    lo = BASE;
    hi = lo + SPAN;
    if (ua < lo || ua >= hi) return 2'b11;
    if (ua % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] exp_resp, input logic exp_wr);
    bit aw_done, w_done;
    int t;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 40) begin
      AWvalid = !aw_done && (t >= aw_dly); AWaddr = addr;
      Wvalid  = !w_done && (t >= w_dly);   Wdata = data; Wstrb = strb;
      @(negedge clk);
      chk("awready_idle", AWready, !aw_done);
      chk("wready_idle", Wready, !w_done);
      if (AWvalid && AWready) aw_done = 1;
      if (Wvalid && Wready) w_done = 1;
      @(posedge clk); #1;
      t++;
    end
    AWvalid = 0; Wvalid = 0;
    if (!(aw_done && w_done)) begin
      fail_timeout("aw_w_accept");
      return;
    end
    if (exp_wr) exp_wr_n++;
    @(negedge clk);
    chk("wr_en", wr_en, exp_wr);
    if (exp_wr) begin
      chk("wr_addr", wr_addr, addr);
      chk("wr_data", wr_data, data);
      chk("wr_strobe", wr_strobe, strb);
    end
    chk("bvalid_early", Bvalid, 1'b0);
    chk("awready_busy", AWready, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i <= b_dly; i++) begin
      Bready = (i == b_dly);
      @(negedge clk);
      chk("bvalid", Bvalid, 1'b1);
      chk("bresp", Bresp, exp_resp);
      chk("wr_en_single", wr_en, 1'b0);
      chk("wready_busy", Wready, 1'b0);
      @(posedge clk); #1;
    end
    Bready = 0;
    @(negedge clk);
    chk("bvalid_clear", Bvalid, 1'b0);
    chk("awready_back", AWready, 1'b1);
    chk("wready_back", Wready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic read_txn(input logic [31:0] addr, input int r_dly, input logic cnst,
                          input logic [1:0] exp_resp);
    bit hs, got, ok;
    int t, e;
    logic [31:0] exp_data;
    hs = 0; got = 0; t = 0;
    rd_const = cnst;
    ARvalid = 1; ARaddr = addr;
    while (!hs && t < 40) begin
      @(negedge clk);
      hs = ARready;
      @(posedge clk); #1;
      t++;
    end
    ARvalid = 0;
    if (!hs) begin
      fail_timeout("ar_accept");
      return;
    end
    e = cyc;
    ok = (exp_resp == 2'b00);
    if (ok) exp_rd_n++;
    exp_data = !ok ? 32'h0 : (cnst ? 32'hCAFE_F00D : rd_val(e + RD_LAT - 1));
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      chk("rd_en", rd_en, ok && (cyc == e));
      if (ok && cyc == e) chk("rd_addr", rd_addr, addr);
      if (Rvalid) begin
        got = 1;
        chk("r_latency", 64'(cyc), 64'(ok ? e + RD_LAT : e));
        chk("rresp", Rresp, exp_resp);
        chk("rdata", Rdata, exp_data);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      fail_timeout("rvalid");
      return;
    end
    for (int j = 0; j <= r_dly; j++) begin
      Rready = (j == r_dly);
      if (j > 0) begin
        @(negedge clk);
        chk("rvalid_hold", Rvalid, 1'b1);
        chk("rdata_stall", Rdata, exp_data);
        chk("arready_busy", ARready, 1'b0);
      end
      @(posedge clk); #1;
    end
    Rready = 0;
    @(negedge clk);
    chk("rvalid_clear", Rvalid, 1'b0);
    chk("arready_back", ARready, 1'b1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  exp_resp;
    logic        exp_wr;
  } wvec_t;

  typedef struct {
    logic [31:0] addr;
    int          r_dly;
    logic        cnst;
    logic [1:0]  exp_resp;
  } rvec_t;

  wvec_t wtab[7];
  rvec_t rtab[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wtab[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    0, 0, 0, 2'b00, 1'b1};
    wtab[1] = '{32'h0000_0020, 32'h1234_5678, 4'b0011, 3, 0, 5, 2'b00, 1'b1};
    wtab[2] = '{32'h0000_1000, 32'h0BAD_0BAD, 4'hF,    0, 0, 1, 2'b11, 1'b0};
    wtab[3] = '{32'h0000_0022, 32'h5555_AAAA, 4'hF,    1, 0, 0, 2'b10, 1'b0};
    wtab[4] = '{32'h0000_0030, 32'h7777_7777, 4'h0,    0, 0, 0, 2'b00, 1'b0};
    wtab[5] = '{32'h0000_0FFC, 32'hA5A5_5A5A, 4'b1000, 0, 2, 2, 2'b00, 1'b1};
    wtab[6] = '{32'hFFFF_F000, 32'h0000_0001, 4'h1,    0, 0, 0, 2'b11, 1'b0};
    rtab[0] = '{32'h0000_0040, 2, 1'b1, 2'b00};
    rtab[1] = '{32'h0000_0042, 1, 1'b0, 2'b10};
    rtab[2] = '{32'h0000_1000, 0, 1'b0, 2'b11};
    rtab[3] = '{32'h0000_0FFC, 0, 1'b0, 2'b00};

    // Reset state
    #3;
    chk("rst_awready", AWready, 1'b0);
    chk("rst_wready", Wready, 1'b0);
    chk("rst_arready", ARready, 1'b0);
    chk("rst_bvalid", Bvalid, 1'b0);
    chk("rst_rvalid", Rvalid, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("rel_awready", AWready, 1'b1);
    chk("rel_wready", Wready, 1'b1);
    chk("rel_arready", ARready, 1'b1);

    foreach (wtab[i])
      write_txn(wtab[i].addr, wtab[i].data, wtab[i].strb, wtab[i].aw_dly, wtab[i].w_dly,
                wtab[i].b_dly, wtab[i].exp_resp, wtab[i].exp_wr);
    foreach (rtab[i])
      read_txn(rtab[i].addr, rtab[i].r_dly, rtab[i].cnst, rtab[i].exp_resp);

    // Same-address write and read issued together
    fork
      write_txn(32'h8, 32'h0102_0304, 4'hF, 0, 0, 0, 2'b00, 1'b1);
      read_txn(32'h8, 0, 1'b0, 2'b00);
    join

    // Randomized concurrent traffic against the decode model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] wa, ra, wd;
      logic [3:0]  ws;
      int k;
      k = $urandom_range(0, 3);
      wa = (k < 2) ? {20'h0, 10'($urandom_range(0, 1023)), 2'b00}
         : (k == 2) ? ({20'h0, 10'($urandom_range(0, 1023)), 2'b00} | 32'($urandom_range(1, 3)))
         : 32'h1000 + 32'($urandom_range(0, 4095));
      k = $urandom_range(0, 3);
      ra = (k < 2) ? {20'h0, 10'($urandom_range(0, 1023)), 2'b00}
         : (k == 2) ? ({20'h0, 10'($urandom_range(0, 1023)), 2'b00} | 32'($urandom_range(1, 3)))
         : $urandom() | 32'h0001_0000;
      wd = $urandom();
      ws = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom());
      fork
        write_txn(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  model_resp(wa), (model_resp(wa) == 2'b00) && (ws != 4'h0));
        read_txn(ra, $urandom_range(0, 3), 1'b0, model_resp(ra));
      join
    end

    // Reset while the write waits in W_RESP and the read waits in R_WAIT
    AWaddr = 32'h8; Wdata = 32'h1111_2222; Wstrb = 4'hF; AWvalid = 1; Wvalid = 1;
    ARaddr = 32'h4; ARvalid = 1; Bready = 0; Rready = 0; rd_const = 0;
    @(negedge clk);
    chk("pre_awready", AWready, 1'b1);
    chk("pre_arready", ARready, 1'b1);
    @(posedge clk); #1;
    AWvalid = 0; Wvalid = 0; ARvalid = 0;
    exp_wr_n++; exp_rd_n++;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_bvalid", Bvalid, 1'b1);
    #1 rst = 0;
    #1;
    chk("arst_bvalid", Bvalid, 1'b0);
    chk("arst_rvalid", Rvalid, 1'b0);
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_rd_en", rd_en, 1'b0);
    chk("arst_awready", AWready, 1'b0);
    chk("arst_arready", ARready, 1'b0);
    @(negedge clk);
    rst = 1;
    Bready = 1; Rready = 1;
    @(posedge clk); #1;
    chk("post_awready", AWready, 1'b1);
    chk("post_wready", Wready, 1'b1);
    chk("post_arready", ARready, 1'b1);
    repeat (8) begin
      @(negedge clk);
      chk("stale_bvalid", Bvalid, 1'b0);
      chk("stale_rvalid", Rvalid, 1'b0);
      chk("stale_rd_en", rd_en, 1'b0);
    end
    Bready = 0; Rready = 0;

    @(posedge clk); #1;
    chk("wr_en_pulses", 64'(n_wr), 64'(exp_wr_n));
    chk("rd_en_pulses", 64'(n_rd), 64'(exp_rd_n));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, mis);
    $finish;
  end

endmodule
`default_nettype wire
